// File: rtl/adc_spi_reader.sv
// SPI front end for a serial ADC: issues a start/single-ended/channel command each frame and
// captures DATA_W result bits into a valid/ready output register with a sticky overrun flag.
`timescale 1ns / 1ps

module adc_spi_reader #(
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clk,
  input  logic              enable,
  input  logic [2:0]        channel,
  input  logic              adc_miso,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              adc_mosi,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int unsigned FrameBits = DATA_W + 6;
  localparam int unsigned CntW      = $clog2(FrameBits);

  localparam logic [CntW-1:0] LastCnt   = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0] FirstData = CntW'(6);
  localparam logic [CntW-1:0] CmdBits   = CntW'(5);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  state_e              state_q, state_d;
  logic                div_q;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]          chan_q, chan_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                tick;
  logic                publish;

  // Command word, first bit on the wire at index 0: start, single-ended, channel MSB-first.
  function automatic logic cmd_bit(input logic [CntW-1:0] idx, input logic [2:0] ch);
    logic b;
    b = 1'b0;
    if (idx < CmdBits) begin
      case (idx[2:0])
        3'd0, 3'd1: b = 1'b1;
        3'd2:       b = ch[2];
        3'd3:       b = ch[1];
        3'd4:       b = ch[0];
        default:    b = 1'b0;
      endcase
    end
    return b;
  endfunction

  always_comb begin
    tick      = div_clk & ~div_q;
    publish   = 1'b0;
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    bit_cnt_d = bit_cnt_q;
    chan_d    = chan_q;
    shreg_d   = shreg_q;

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d   = StShift;
            chan_d    = channel;
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            bit_cnt_d = '0;
            mosi_d    = cmd_bit('0, channel);
          end
        end
        StShift: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (bit_cnt_q >= FirstData) shreg_d = {shreg_q[DATA_W-2:0], adc_miso};
          end else if (bit_cnt_q < LastCnt) begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + CntW'(1);
            mosi_d    = cmd_bit(bit_cnt_q + CntW'(1), chan_q);
          end else begin
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            publish = 1'b1;
            state_d = StHold;
          end
        end
        StHold:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // A publish always wins over an accept; overrun only when pending data is lost.
  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (publish) begin
      sample_d = shreg_q;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      bit_cnt_q <= '0;
      chan_q    <= '0;
      shreg_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_clk;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      bit_cnt_q <= bit_cnt_d;
      chan_q    <= chan_d;
      shreg_q   <= shreg_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_mosi     = mosi_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
